// File: rtl/obi_sram_responder.sv
// OBI subordinate backed by a byte-writable SRAM with a fixed-latency, in-order
// response pipeline and a bounded number of outstanding transactions.
package obi_sram_pkg;
  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;
endpackage

module obi_sram_responder
  import obi_sram_pkg::*;
#(
  parameter int NUM_WORDS       = 256,
  parameter int RESP_LATENCY    = 1,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  obi_req_t  obi_req_i,
  output obi_resp_t obi_resp_o,
  input  logic      gnt_stall_i
);
  localparam int AW = $clog2(NUM_WORDS);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  logic [31:0]             mem_q   [NUM_WORDS];
  logic [RESP_LATENCY-1:0] valid_q, valid_d;
  logic [31:0]             rdata_q [RESP_LATENCY];
  logic [31:0]             rdata_d [RESP_LATENCY];
  logic [CW-1:0]           cnt_q, cnt_d, cnt_after;
  logic [AW-1:0]           word;
  logic                    retiring, gnt, hs;
  logic                    unused_addr_bits;

  // Low byte-offset and high bits do not select a word, so high addresses wrap.
  assign word             = obi_req_i.addr[2 +: AW];
  assign unused_addr_bits = ^{obi_req_i.addr[31:2+AW], obi_req_i.addr[1:0]};

  assign retiring  = valid_q[RESP_LATENCY-1];
  assign cnt_after = cnt_q - CW'(retiring);
  assign gnt       = obi_req_i.req & ~gnt_stall_i & ~rst_i & (cnt_after < CW'(MAX_OUTSTANDING));
  assign hs        = obi_req_i.req & gnt;

  // NOTE: always_comb uses blocking '=' and gives every output a default first, so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (hs && !retiring)      cnt_d = cnt_q + CW'(1);
    else if (!hs && retiring) cnt_d = cnt_q - CW'(1);

    valid_d    = RESP_LATENCY'({valid_q, hs});
    rdata_d    = rdata_q;
    rdata_d[0] = (hs && !obi_req_i.we) ? mem_q[word] : '0;
    for (int i = 1; i < RESP_LATENCY; i++) rdata_d[i] = rdata_q[i-1];
  end

  // NOTE: sequential state uses non-blocking '<=' so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      valid_q <= '0;
      for (int i = 0; i < RESP_LATENCY; i++) rdata_q[i] <= '0;
    end else begin
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      for (int i = 0; i < RESP_LATENCY; i++) rdata_q[i] <= rdata_d[i];
    end
  end

  // NOTE: the array is deliberately not reset so it maps onto a RAM; contents survive rst_i.
  always_ff @(posedge clk_i) begin
    if (hs && obi_req_i.we) begin
      for (int b = 0; b < 4; b++) begin
        if (obi_req_i.be[b]) mem_q[word][8*b +: 8] <= obi_req_i.wdata[8*b +: 8];
      end
    end
  end

  always_comb begin
    obi_resp_o        = '0;
    obi_resp_o.gnt    = gnt;
    obi_resp_o.rvalid = retiring;
    obi_resp_o.rdata  = retiring ? rdata_q[RESP_LATENCY-1] : '0;
  end
endmodule

// File: doc/obi_sram_responder.md
OBI_SRAM_RESPONDER -- requirements
Module: obi_sram_responder

Interface
REQ-001 SHALL have parameter NUM_WORDS, default 256, memory depth in 32-bit words (power of two, at least 2).
REQ-002 SHALL have parameter RESP_LATENCY, default 1, number of cycles from grant to rvalid (legal range 1..4).
REQ-003 SHALL have parameter MAX_OUTSTANDING, default 2, maximum granted-but-unanswered transactions (legal range 1..RESP_LATENCY+1).
REQ-004 SHALL have port clk_i, input, 1 bit, the single clock; all state rises on its rising edge.
REQ-005 SHALL have port rst_i, input, 1 bit, reset; asynchronous, active-high.
REQ-006 SHALL have port obi_req_i, input, obi_req_t (req, addr[31:0], we, be[3:0], wdata[31:0]), OBI request from the initiator.
REQ-007 SHALL have port obi_resp_o, output, obi_resp_t (gnt, rvalid, rdata[31:0]), OBI response to the initiator.
REQ-008 SHALL have port gnt_stall_i, input, 1 bit; when high it forces gnt low for back-pressure injection.

Function
REQ-009 SHALL drive gnt combinationally as req AND NOT gnt_stall_i AND (outstanding_cnt minus retiring) < MAX_OUTSTANDING.
- retiring is 1 when rvalid is high in the current cycle.
REQ-010 SHALL accept a transaction only in a cycle where req and gnt are both high (the handshake cycle).
REQ-011 SHALL index the memory with word = addr[2 +: log2(NUM_WORDS)].
- addr[1:0] and the upper address bits are ignored, so out-of-range addresses alias (wrap) modulo NUM_WORDS.
REQ-012 SHALL, on a handshake with we=1, update only the bytes whose be bit is set.
- The update is visible at the clock edge ending the handshake cycle.
REQ-013 SHALL, on a handshake with we=0, sample memory[word] in the handshake cycle.
- A write handshaked in cycle N is visible to a read handshaked in cycle N+1.
REQ-014 SHALL assert rvalid for exactly one cycle, exactly RESP_LATENCY cycles after each handshake, via a RESP_LATENCY-stage shift pipeline of {valid, rdata}.
REQ-015 SHALL return responses in handshake order; rvalid is never withheld, since the protocol has no rready.
REQ-016 SHALL drive rdata to the sampled word for read responses, and to 32'h0 for write responses and whenever rvalid is low.
REQ-017 SHALL maintain outstanding_cnt with width clog2(MAX_OUTSTANDING+1).
- +1 on a handshake, -1 on rvalid, unchanged when both occur in the same cycle.
- Never exceeds MAX_OUTSTANDING and never underflows.
REQ-018 SHALL sustain one handshake per cycle (back-to-back) whenever MAX_OUTSTANDING >= RESP_LATENCY.
REQ-019 SHALL ignore we, be, addr and wdata while req is low or gnt is low.
REQ-020 SHALL accept be=4'b0000 writes as legal handshakes that leave memory unchanged and still produce a response.

Reset
REQ-021 SHALL, while rst_i is high, immediately force gnt=0, rvalid=0, rdata=0, clear outstanding_cnt and clear all pipeline valid bits.
REQ-022 SHALL drop in-flight responses on reset mid-operation; no rvalid appears for transactions granted before reset.
REQ-023 SHALL leave memory contents unreset; they are undefined after power-up and retained across rst_i pulses.
REQ-024 SHALL grant, on the first rising edge after rst_i deasserts, if req is high and gnt_stall_i is low.

Verification
REQ-025 SHALL pass: write 0xDEADBEEF to addr 0x10 with be=4'hF, then read 0x10 the next cycle -> rvalid 1 cycle later (RESP_LATENCY=1), rdata=0xDEADBEEF.
REQ-026 SHALL pass: after REQ-025, write 0x0000AA00 with be=4'b0010 to 0x10, then read -> rdata=0xDEADAAEF.
REQ-027 SHALL pass: with NUM_WORDS=256, write 0x12345678 to 0x400, read 0x000 -> rdata=0x12345678 (alias).
REQ-028 SHALL pass: with RESP_LATENCY=3 and MAX_OUTSTANDING=2, hold req high for 4 cycles -> gnt pattern 1,1,0,1.
- rvalid arrives 3 cycles after each grant; outstanding_cnt never exceeds 2.
REQ-029 SHALL pass: gnt_stall_i high for 3 cycles while req is high -> gnt=0 for those cycles.
- The request is granted in the first cycle gnt_stall_i is low, with addr/we held stable.
REQ-030 SHALL pass: pulse rst_i while 2 reads are in flight -> no rvalid afterwards, outstanding_cnt=0.
- Memory data written before reset still reads back correctly.
